// File: rtl/adder_arbiter.sv
// adder_arbiter: three requesters share one WIDTH-bit signed adder.
// A round-robin arbiter grants in IDLE, the operands are summed in EXEC,
// and the result is held in DONE until the consumer accepts it.
module adder_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] b2,
  output logic [2:0]       gnt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [1:0]       res_id,
  output logic             res_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              ptr_q, ptr_d;
  logic signed [WIDTH-1:0] op_a_q, op_a_d;
  logic signed [WIDTH-1:0] op_b_q, op_b_d;
  logic [1:0]              op_id_q, op_id_d;
  logic signed [WIDTH-1:0] res_data_q, res_data_d;
  logic [1:0]              res_id_q, res_id_d;
  logic                    res_ovf_q, res_ovf_d;

  logic                    found;
  logic [1:0]              win;
  logic [1:0]              cand;
  logic signed [WIDTH-1:0] sel_a, sel_b;
  logic signed [WIDTH-1:0] sum;

  // Successor of a requester index in the 0 -> 1 -> 2 -> 0 ring.
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Wrap-around sum; the carry out is deliberately dropped.
  function automatic logic signed [WIDTH-1:0] add_wrap(
    input logic signed [WIDTH-1:0] x,
    input logic signed [WIDTH-1:0] y
  );
    return x + y;
  endfunction

  // Signed overflow: like-signed operands whose sum flipped sign.
  function automatic logic add_ovf(
    input logic signed [WIDTH-1:0] x,
    input logic signed [WIDTH-1:0] y,
    input logic signed [WIDTH-1:0] s
  );
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  // Round-robin search starting at ptr; grant only in IDLE and never during reset.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    cand  = ptr_q;
    if (state_q == S_IDLE && !rst) begin
      for (int k = 0; k < 3; k++) begin
        if (!found && req[cand]) begin
          found = 1'b1;
          win   = cand;
        end
        cand = next_idx(cand);
      end
    end
    gnt = found ? (3'b001 << win) : 3'b000;
  end

  // Operand mux for the winning requester.
  always_comb begin
    case (win)
      2'd0:    begin sel_a = a0; sel_b = b0; end
      2'd1:    begin sel_a = a1; sel_b = b1; end
      default: begin sel_a = a2; sel_b = b2; end
    endcase
  end

  assign sum = add_wrap(op_a_q, op_b_q);

  // Next-state and register-update logic for the IDLE/EXEC/DONE sequence.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_id_d    = op_id_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    res_ovf_d  = res_ovf_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          op_a_d  = sel_a;
          op_b_d  = sel_b;
          op_id_d = win;
          ptr_d   = next_idx(win);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_data_d = sum;
        res_ovf_d  = add_ovf(op_a_q, op_b_q, sum);
        res_id_d   = op_id_q;
        state_d    = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and result registers; reset returns to an empty, idle block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= 2'd0;
      res_data_q <= '0;
      res_id_q   <= 2'd0;
      res_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
      res_ovf_q  <= res_ovf_d;
    end
  end

  // Captured operands need no reset: they are only read after a grant loads them.
  always_ff @(posedge clk) begin
    op_a_q  <= op_a_d;
    op_b_q  <= op_b_d;
    op_id_q <= op_id_d;
  end

  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: stimulus pushes expected results,
// a monitor pops and compares at every result handshake.
module tb_adder_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [31:0] a0, b0, a1, b1, a2, b2;
  logic [2:0]  gnt;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [1:0]  res_id;
  logic        res_ovf;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    logic        ovf;
  } exp_t;

  exp_t q[$];

  adder_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .a2(a2), .b2(b2),
    .gnt(gnt), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .res_ovf(res_ovf), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [1:0] id, input logic [31:0] a, input logic [31:0] b);
    case (id)
      2'd0:    begin a0 = a; b0 = b; end
      2'd1:    begin a1 = a; b1 = b; end
      default: begin a2 = a; b2 = b; end
    endcase
  endtask

  task automatic expect_res(input logic [1:0] id, input logic [31:0] d, input logic o);
    exp_t e;
    e.id = id; e.data = d; e.ovf = o;
    q.push_back(e);
  endtask

  // One lone request from idle, consumer always ready: 3 cycles end to end.
  task automatic run_one(input logic [1:0] id, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_d, input logic exp_o);
    logic [2:0] onehot;
    onehot = 3'b001 << id;
    set_ops(id, a, b);
    req = onehot;
    expect_res(id, exp_d, exp_o);
    @(negedge clk); chk("run_gnt", {29'd0, gnt}, {29'd0, onehot});
    next_cycle(); req = 3'b000;
    @(negedge clk); chk("run_exec_busy", {31'd0, busy}, 32'd1);
    chk("run_exec_valid", {31'd0, res_valid}, 32'd0);
    next_cycle();
    @(negedge clk); chk("run_done_valid", {31'd0, res_valid}, 32'd1);
    next_cycle();
  endtask

  // Monitor: every accepted result must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && res_valid && res_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got id=%0d data=%h with no result outstanding", res_id, res_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("res_data", res_data, e.data);
          chk("res_id", {30'd0, res_id}, {30'd0, e.id});
          chk("res_ovf", {31'd0, res_ovf}, {31'd0, e.ovf});
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [2:0] rr_exp [4];

  initial begin
    rst = 1'b1; req = 3'b111; res_ready = 1'b1;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); chk("gnt_in_reset", {29'd0, gnt}, 32'd0);
    next_cycle(); rst = 1'b0; req = 3'b000;
    @(negedge clk);
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_data", res_data, 32'd0);
    chk("rst_id", {30'd0, res_id}, 32'd0);
    chk("rst_ovf", {31'd0, res_ovf}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_gnt", {29'd0, gnt}, 32'd0);
    next_cycle();

    // Single request 5 + 7.
    run_one(2'd0, 32'd5, 32'd7, 32'd12, 1'b0);
    @(negedge clk); chk("idle_after_hs_valid", {31'd0, res_valid}, 32'd0);
    chk("idle_after_hs_busy", {31'd0, busy}, 32'd0);
    next_cycle();

    // Round robin from ptr 0 after a fresh reset.
    rst = 1'b1;
    next_cycle(); rst = 1'b0;
    set_ops(2'd0, 32'd1, 32'd2);
    set_ops(2'd1, 32'd10, 32'd20);
    set_ops(2'd2, 32'd100, 32'd200);
    req = 3'b111;
    expect_res(2'd0, 32'd3, 1'b0);
    expect_res(2'd1, 32'd30, 1'b0);
    expect_res(2'd2, 32'd300, 1'b0);
    expect_res(2'd0, 32'd3, 1'b0);
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk("rr_gnt", {29'd0, gnt}, (c == 0) ? {29'd0, rr_exp[k]} : 32'd0);
        next_cycle();
        if (k == 3 && c == 0) req = 3'b000;
      end
    end

    // Overflow vectors.
    run_one(2'd1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1);
    run_one(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    run_one(2'd1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
    run_one(2'd2, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);

    // Backpressure: ptr is 0 here (last grant went to 2).
    res_ready = 1'b0;
    set_ops(2'd0, 32'hFFFF_FFEC, 32'd5);
    req = 3'b001;
    expect_res(2'd0, 32'hFFFF_FFF1, 1'b0);
    @(negedge clk); chk("bp_gnt0", {29'd0, gnt}, 32'b001);
    next_cycle();
    set_ops(2'd1, 32'd11, 32'd22);
    set_ops(2'd2, 32'd33, 32'd44);
    req = 3'b110;
    expect_res(2'd1, 32'd33, 1'b0);
    expect_res(2'd2, 32'd77, 1'b0);
    @(negedge clk); chk("bp_exec_gnt", {29'd0, gnt}, 32'd0);
    next_cycle();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, res_valid}, 32'd1);
      chk("bp_data", res_data, 32'hFFFF_FFF1);
      chk("bp_id", {30'd0, res_id}, 32'd0);
      chk("bp_gnt", {29'd0, gnt}, 32'd0);
      next_cycle();
    end
    res_ready = 1'b1;
    @(negedge clk); chk("bp_release_valid", {31'd0, res_valid}, 32'd1);
    next_cycle();
    @(negedge clk); chk("bp_next_gnt", {29'd0, gnt}, 32'b010);
    next_cycle();
    repeat (2) begin @(negedge clk); next_cycle(); end
    @(negedge clk); chk("bp_third_gnt", {29'd0, gnt}, 32'b100);
    next_cycle(); req = 3'b000;
    repeat (2) begin @(negedge clk); next_cycle(); end

    // Reset during EXEC: ptr would be 1, reset forces it back to 0.
    set_ops(2'd0, 32'd1, 32'd1);
    req = 3'b001;
    @(negedge clk); chk("rstx_gnt", {29'd0, gnt}, 32'b001);
    next_cycle(); req = 3'b000; rst = 1'b1;
    @(negedge clk); chk("rstx_gnt_in_rst", {29'd0, gnt}, 32'd0);
    next_cycle(); rst = 1'b0;
    set_ops(2'd0, 32'd40, 32'd2);
    set_ops(2'd1, 32'd9, 32'd9);
    req = 3'b011;
    expect_res(2'd0, 32'd42, 1'b0);
    @(negedge clk);
    chk("rstx_valid", {31'd0, res_valid}, 32'd0);
    chk("rstx_busy", {31'd0, busy}, 32'd0);
    chk("rstx_ptr0_gnt", {29'd0, gnt}, 32'b001);
    next_cycle(); req = 3'b000;
    repeat (2) begin @(negedge clk); next_cycle(); end
    run_one(2'd1, 32'd6, 32'd4, 32'd10, 1'b0);

    // Late request raised in EXEC waits for IDLE.
    set_ops(2'd0, 32'd3, 32'd4);
    req = 3'b001;
    expect_res(2'd0, 32'd7, 1'b0);
    @(negedge clk); chk("late_gnt0", {29'd0, gnt}, 32'b001);
    next_cycle();
    set_ops(2'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFC);
    req = 3'b100;
    expect_res(2'd2, 32'hFFFF_FFF9, 1'b0);
    @(negedge clk); chk("late_exec_gnt", {29'd0, gnt}, 32'd0);
    next_cycle();
    @(negedge clk); chk("late_done_gnt", {29'd0, gnt}, 32'd0);
    next_cycle();
    @(negedge clk); chk("late_gnt2", {29'd0, gnt}, 32'b100);
    next_cycle(); req = 3'b000;
    repeat (4) begin @(negedge clk); next_cycle(); end

    chk("queue_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
